// File: rtl/iob_soc_opencryptolinux_boot_copy_pkg.sv
// Shared types and helpers for the boot-ROM-to-SRAM copy engine.
package iob_soc_opencryptolinux_boot_copy_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StRd    = 3'd2,
    StCap   = 3'd3,
    StWr    = 3'd4
  } state_e;

  // log2 of the word size in bytes, used to turn a word index into a byte address
  function automatic int unsigned byte_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_soc_opencryptolinux_boot_copy_fsm.sv
// Copy sequencer: state register, word counter and sticky completion flag.
module iob_soc_opencryptolinux_boot_copy_fsm
  import iob_soc_opencryptolinux_boot_copy_pkg::*;
#(
  parameter int unsigned ROM_ADDR_W = 10,
  parameter int unsigned BOOT_WORDS = 2 ** ROM_ADDR_W
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                boot_i,
  input  logic                cpu_reset_i,
  input  logic                sram_ready_i,
  output logic [2:0]          state_o,
  output logic [ROM_ADDR_W:0] cnt_o,
  output logic                copy_done_o
);

  localparam logic [ROM_ADDR_W:0] LastCnt = (ROM_ADDR_W + 1)'(BOOT_WORDS - 1);

  state_e              state_q, state_d;
  logic [ROM_ADDR_W:0] cnt_q, cnt_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      StIdle: begin
        if (cpu_reset_i) state_d = StArmed;
      end
      StArmed: begin
        if (!cpu_reset_i) begin
          if (boot_i) begin
            state_d = StRd;
            cnt_d   = '0;
            done_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRd, StCap: begin
        if (cpu_reset_i) begin
          state_d = StArmed;
          cnt_d   = '0;
        end else begin
          state_d = (state_q == StRd) ? StCap : StWr;
        end
      end
      StWr: begin
        // An abort seen here waits for the in-flight handshake to finish.
        if (sram_ready_i) begin
          if (cnt_q == LastCnt) begin
            done_d  = 1'b1;
            state_d = cpu_reset_i ? StArmed : StIdle;
          end else if (cpu_reset_i) begin
            state_d = StArmed;
            cnt_d   = '0;
          end else begin
            state_d = StRd;
            cnt_d   = cnt_q + (ROM_ADDR_W + 1)'(1);
          end
        end
      end
      default: begin
        state_d = StArmed;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StArmed;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign state_o     = state_q;
  assign cnt_o       = cnt_q;
  assign copy_done_o = done_q;

endmodule

// File: rtl/iob_soc_opencryptolinux_boot_copy.sv
// Copies the boot ROM image into SRAM after a boot-mode CPU reset, holding the CPU in reset
// until the copy completes.
module iob_soc_opencryptolinux_boot_copy
  import iob_soc_opencryptolinux_boot_copy_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROM_ADDR_W  = 10,
  parameter int unsigned SRAM_ADDR_W = 16,
  parameter int unsigned BOOT_WORDS  = 2 ** ROM_ADDR_W,
  parameter int unsigned DST_BASE    = 0
) (
  input  logic                   clk_i,
  input  logic                   arst_n_i,
  input  logic                   cke_i,
  input  logic                   boot_i,
  input  logic                   cpu_reset_i,
  output logic                   cpu_reset_o,
  output logic                   copy_done_o,
  output logic                   rom_en_o,
  output logic [ROM_ADDR_W-1:0]  rom_addr_o,
  input  logic [DATA_W-1:0]      rom_rdata_i,
  output logic                   sram_avalid_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0]      sram_wdata_o,
  output logic [DATA_W/8-1:0]    sram_wstrb_o,
  input  logic                   sram_ready_i
);

  localparam int unsigned StrbW     = DATA_W / 8;
  localparam int unsigned ByteShift = byte_shift(DATA_W);

  logic [2:0]             state_raw;
  state_e                 state;
  logic [ROM_ADDR_W:0]    cnt;
  logic [DATA_W-1:0]      wdata_q;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;

  iob_soc_opencryptolinux_boot_copy_fsm #(
    .ROM_ADDR_W(ROM_ADDR_W),
    .BOOT_WORDS(BOOT_WORDS)
  ) u_fsm (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .boot_i      (boot_i),
    .cpu_reset_i (cpu_reset_i),
    .sram_ready_i(sram_ready_i),
    .state_o     (state_raw),
    .cnt_o       (cnt),
    .copy_done_o (copy_done_o)
  );

  assign state  = state_e'(state_raw);
  assign addr_d = SRAM_ADDR_W'(DST_BASE) + (SRAM_ADDR_W'(cnt) << ByteShift);

  // Request payload is captured once per word so it stays stable through ready stalls.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wdata_q <= '0;
      addr_q  <= '0;
    end else if (cke_i && state == StCap) begin
      wdata_q <= rom_rdata_i;
      addr_q  <= addr_d;
    end
  end

  assign cpu_reset_o   = cpu_reset_i | (state != StIdle);
  assign rom_en_o      = (state == StRd);
  assign rom_addr_o    = cnt[ROM_ADDR_W-1:0];
  assign sram_avalid_o = (state == StWr);
  assign sram_addr_o   = addr_q;
  assign sram_wdata_o  = wdata_q;
  assign sram_wstrb_o  = sram_avalid_o ? {StrbW{1'b1}} : '0;

endmodule

// File: tb/tb_iob_soc_opencryptolinux_boot_copy.sv
// Self-checking bench: SRAM write scoreboard plus a table of ready-stall copy scenarios.
module tb_iob_soc_opencryptolinux_boot_copy;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        cke;
  logic        boot;
  logic        cpu_reset_i;
  logic        cpu_reset_o;
  logic        copy_done;
  logic        rom_en;
  logic [2:0]  rom_addr;
  logic [31:0] rom_rdata = 32'h0;
  logic        sram_avalid;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int rom_en_cnt = 0;
  int avalid_cnt = 0;
  int stall_word = -1;
  int stall_left = 0;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    int stall_word;
    int stall_cycles;
    int exp_hi;
  } vec_t;

  iob_soc_opencryptolinux_boot_copy #(
    .DATA_W     (32),
    .ROM_ADDR_W (3),
    .SRAM_ADDR_W(16),
    .BOOT_WORDS (8),
    .DST_BASE   (32'h100)
  ) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .cke_i        (cke),
    .boot_i       (boot),
    .cpu_reset_i  (cpu_reset_i),
    .cpu_reset_o  (cpu_reset_o),
    .copy_done_o  (copy_done),
    .rom_en_o     (rom_en),
    .rom_addr_o   (rom_addr),
    .rom_rdata_i  (rom_rdata),
    .sram_avalid_o(sram_avalid),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wstrb_o (sram_wstrb),
    .sram_ready_i (sram_ready)
  );

  always #5 clk = ~clk;

  // Boot ROM model: ROM[i] = 0xA0 + i, one cycle read latency.
  always @(posedge clk) if (rom_en) rom_rdata <= 32'hA0 + 32'(rom_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{16'(32'h100 + 4 * i), 32'hA0 + 32'(i)});
  endtask

  // Ready driver: hold ready low for stall_left cycles on the chosen word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sram_avalid && stall_left > 0 && sram_addr == 16'(32'h100 + 4 * stall_word)) begin
        sram_ready = 1'b0;
        stall_left--;
      end else begin
        sram_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rom_en) rom_en_cnt++;
    if (sram_avalid) begin
      avalid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_request", 32'(sram_addr), 32'hFFFF_FFFF);
      end else if (sram_ready) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(sram_addr), 32'(e.addr));
        check("wr_data", sram_wdata, e.data);
        check("wr_strb", 32'(sram_wstrb), 32'hF);
      end else begin
        check("stall_addr", 32'(sram_addr), 32'(exp_q[0].addr));
        check("stall_data", sram_wdata, exp_q[0].data);
      end
    end
  end

  // Counts cycles with cpu_reset_o high until it drops.
  task automatic wait_low(inout int hi);
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!cpu_reset_o) begin
        ok = 1'b1;
        break;
      end
      hi++;
    end
    if (!ok) check("cpu_reset_o_timeout", 32'(cpu_reset_o), 32'h0);
  endtask

  task automatic pulse(input int n, input logic b, output int hi);
    hi = 0;
    @(posedge clk);
    #1;
    boot = b;
    cpu_reset_i = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (cpu_reset_o) hi++;
      @(posedge clk);
      #1;
    end
    cpu_reset_i = 1'b0;
  endtask

  task automatic wait_for(input bit want_rd, input logic [15:0] a, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (want_rd ? (rom_en && 16'(rom_addr) == a) : (sram_avalid && sram_addr == a)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(nm, 32'h0, 32'h1);
  endtask

  vec_t vecs[4];

  initial begin
    int hi;
    int h2;
    int rc;
    int ac;
    vecs[0] = '{-1, 0, 26};
    vecs[1] = '{3, 5, 31};
    vecs[2] = '{0, 2, 28};
    vecs[3] = '{7, 1, 27};

    arst_n = 1'b0;
    cke = 1'b1;
    boot = 1'b1;
    cpu_reset_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset_o", 32'(cpu_reset_o), 32'h1);
    check("rst_copy_done", 32'(copy_done), 32'h0);
    check("rst_rom_en", 32'(rom_en), 32'h0);
    check("rst_avalid", 32'(sram_avalid), 32'h0);
    check("rst_wstrb", 32'(sram_wstrb), 32'h0);

    // 1: copy straight out of reset
    push_words(8);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    hi = 0;
    wait_low(hi);
    check("t1_reset_cycles", 32'(hi), 32'd25);
    check("t1_copy_done", 32'(copy_done), 32'h1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'h0);

    // Table: copies with a ready stall on one word
    foreach (vecs[v]) begin
      stall_word = vecs[v].stall_word;
      push_words(8);
      pulse(1, 1'b1, hi);
      stall_left = vecs[v].stall_cycles;
      wait_low(hi);
      check($sformatf("tbl%0d_reset_cycles", v), 32'(hi), 32'(vecs[v].exp_hi));
      check($sformatf("tbl%0d_copy_done", v), 32'(copy_done), 32'h1);
      check($sformatf("tbl%0d_queue_empty", v), 32'(exp_q.size()), 32'h0);
      check($sformatf("tbl%0d_stall_used", v), 32'(stall_left), 32'h0);
    end

    // 2: boot=0 only forwards the reset, one cycle longer
    rc = rom_en_cnt;
    ac = avalid_cnt;
    pulse(100, 1'b0, hi);
    wait_low(hi);
    check("t2_reset_cycles", 32'(hi), 32'd101);
    check("t2_no_rom_en", 32'(rom_en_cnt - rc), 32'h0);
    check("t2_no_avalid", 32'(avalid_cnt - ac), 32'h0);
    check("t2_copy_done_kept", 32'(copy_done), 32'h1);

    // 4: abort while capturing word 4
    push_words(4);
    push_words(8);
    pulse(1, 1'b1, hi);
    wait_for(1'b1, 16'd4, "t4_reach_word4");
    pulse(10, 1'b1, hi);
    check("t4_pulse_cycles", 32'(hi), 32'd10);
    h2 = 0;
    wait_low(h2);
    check("t4_restart_cycles", 32'(h2), 32'd25);
    check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

    // 5: abort during a stalled write of word 2; that write still completes
    push_words(3);
    push_words(8);
    stall_word = 2;
    pulse(1, 1'b1, hi);
    stall_left = 3;
    wait_for(1'b0, 16'h108, "t5_reach_word2");
    pulse(10, 1'b1, hi);
    h2 = 0;
    wait_low(h2);
    check("t5_restart_cycles", 32'(h2), 32'd25);
    check("t5_queue_empty", 32'(exp_q.size()), 32'h0);
    check("t5_copy_done", 32'(copy_done), 32'h1);

    // 6: asynchronous reset in the write of word 5
    push_words(5);
    push_words(8);
    pulse(1, 1'b1, hi);
    wait_for(1'b1, 16'd5, "t6_reach_word5");
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_in_write", 32'(sram_avalid), 32'h1);
    arst_n = 1'b0;
    #1;
    check("t6_avalid_drop", 32'(sram_avalid), 32'h0);
    check("t6_cpu_reset_o", 32'(cpu_reset_o), 32'h1);
    check("t6_copy_done_clr", 32'(copy_done), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    hi = 0;
    wait_low(hi);
    check("t6_recopy_cycles", 32'(hi), 32'd25);
    check("t6_queue_empty", 32'(exp_q.size()), 32'h0);
    check("t6_copy_done", 32'(copy_done), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
